// File: rtl/wf_pending_rr_scheduler.sv
// Wavefront pending-flag tracker with a round-robin pick and a one-entry
// registered valid/ready grant stage.
module wf_pending_rr_scheduler #(
  parameter int unsigned NUM_WF  = 40,
  parameter int unsigned WF_ID_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  set_vec,
  input  logic [NUM_WF-1:0]  clear_vec,
  input  logic               halt,
  output logic               grant_valid,
  output logic [WF_ID_W-1:0] grant_wfid,
  input  logic               grant_ready,
  output logic [NUM_WF-1:0]  pending_vec,
  output logic               pending_any
);

  logic [NUM_WF-1:0]  pending_q;
  logic [WF_ID_W-1:0] last_ptr;
  logic [WF_ID_W-1:0] sel;
  logic [NUM_WF-1:0]  grant_clear;
  logic               free;
  logic               load;

  assign pending_vec = pending_q;
  assign pending_any = |pending_q;
  assign free        = !grant_valid || grant_ready;
  assign load        = free && !halt && pending_any;

  // Round-robin search starting just after last_ptr and ending on it,
  // wrapping at NUM_WF; the first pending slot found wins.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic        found;
    sel   = '0;
    found = 1'b0;
    base  = 32'(last_ptr);
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_WF; k++) begin
      idx = base + k;
      if (idx >= NUM_WF) idx = idx - NUM_WF;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = WF_ID_W'(idx);
      end
    end
  end

  // One-hot clear of the slot being loaded into the output stage.
  always_comb begin
    grant_clear = '0;
    if (load) grant_clear[sel] = 1'b1;
  end

  // Pending flags: set dominates explicit clear and grant clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= set_vec | (pending_q & ~(clear_vec | grant_clear));
    end
  end

  // Output stage and round-robin pointer; a stalled grant is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid <= 1'b0;
      grant_wfid  <= '0;
      last_ptr    <= WF_ID_W'(NUM_WF - 1);
    end else if (load) begin
      grant_valid <= 1'b1;
      grant_wfid  <= sel;
      last_ptr    <= sel;
    end else if (free) begin
      grant_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wf_pending_rr_scheduler.sv
// Directed bench for wf_pending_rr_scheduler with hand-computed expectations.
module tb_wf_pending_rr_scheduler;

  localparam int unsigned NUM_WF  = 40;
  localparam int unsigned WF_ID_W = 6;

  logic               clk;
  logic               rst;
  logic [NUM_WF-1:0]  set_vec;
  logic [NUM_WF-1:0]  clear_vec;
  logic               halt;
  logic               grant_valid;
  logic [WF_ID_W-1:0] grant_wfid;
  logic               grant_ready;
  logic [NUM_WF-1:0]  pending_vec;
  logic               pending_any;

  int tests;
  int fails;

  wf_pending_rr_scheduler #(
    .NUM_WF  (NUM_WF),
    .WF_ID_W (WF_ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_vec     (set_vec),
    .clear_vec   (clear_vec),
    .halt        (halt),
    .grant_valid (grant_valid),
    .grant_wfid  (grant_wfid),
    .grant_ready (grant_ready),
    .pending_vec (pending_vec),
    .pending_any (pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_WF-1:0] oh(input int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_is(input string tag, input logic v, input int id);
    check({tag, "_valid"}, 64'(grant_valid), 64'(v));
    if (v) check({tag, "_wfid"}, 64'(grant_wfid), 64'(id));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; set_vec = '0; clear_vec = '0; halt = 1'b0; grant_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 64'(grant_valid), 64'd0);
    check("rst_wfid", 64'(grant_wfid), 64'd0);
    check("rst_pend", 64'(pending_vec), 64'd0);
    check("rst_any", 64'(pending_any), 64'd0);
    rst = 1'b0;

    // Single slot 0: pending after E0, granted after E1, then idle.
    set_vec = oh(0);
    tick();
    set_vec = '0;
    check("s0_pend", 64'(pending_vec), 64'(oh(0)));
    check("s0_any", 64'(pending_any), 64'd1);
    check("s0_novalid", 64'(grant_valid), 64'd0);
    tick();
    grant_is("s0_g", 1'b1, 0);
    check("s0_clr", 64'(pending_vec), 64'd0);
    tick();
    grant_is("s0_idle", 1'b0, 0);
    check("s0_wfid_hold", 64'(grant_wfid), 64'd0);

    // {3,7,39} back to back, then {0,5} wrapping past 39.
    set_vec = oh(3) | oh(7) | oh(39);
    tick();
    set_vec = '0;
    tick(); grant_is("rr_3", 1'b1, 3);
    tick(); grant_is("rr_7", 1'b1, 7);
    tick(); grant_is("rr_39", 1'b1, 39);
    set_vec = oh(0) | oh(5);
    tick();
    set_vec = '0;
    grant_is("rr_gap", 1'b0, 0);
    tick(); grant_is("wrap_0", 1'b1, 0);
    tick(); grant_is("wrap_5", 1'b1, 5);
    tick(); grant_is("wrap_idle", 1'b0, 0);

    // Stall: grant 7 held for 5 cycles while 9 becomes pending.
    set_vec = oh(7);
    tick();
    set_vec = '0;
    grant_ready = 1'b0;
    tick(); grant_is("stall_7", 1'b1, 7);
    set_vec = oh(9);
    for (int i = 0; i < 5; i++) begin
      tick();
      grant_is("stall_hold", 1'b1, 7);
    end
    check("stall_pend9", 64'(pending_vec), 64'(oh(9)));
    set_vec = '0;
    grant_ready = 1'b1;
    tick(); grant_is("stall_next9", 1'b1, 9);
    tick(); grant_is("stall_idle", 1'b0, 0);

    // Set during grant of the same slot keeps it pending; re-granted (equals last_ptr).
    set_vec = oh(4);
    tick();
    tick(); grant_is("reset_4a", 1'b1, 4);
    check("reset_4_pend", 64'(pending_vec), 64'(oh(4)));
    set_vec = '0;
    tick(); grant_is("reset_4b", 1'b1, 4);
    check("reset_4_clr", 64'(pending_vec), 64'd0);
    tick(); grant_is("reset_4_idle", 1'b0, 0);

    // Set beats clear; clear alone drops slot 6 so only 2 is granted.
    halt = 1'b1;
    set_vec = oh(2) | oh(6);
    tick();
    set_vec = oh(6); clear_vec = oh(6);
    tick();
    check("setclr_pend", 64'(pending_vec), 64'(oh(2) | oh(6)));
    grant_is("setclr_halt", 1'b0, 0);
    set_vec = '0;
    tick();
    check("clr6_pend", 64'(pending_vec), 64'(oh(2)));
    clear_vec = '0; halt = 1'b0;
    tick(); grant_is("clr6_g2", 1'b1, 2);
    tick(); grant_is("clr6_idle", 1'b0, 0);
    check("clr6_empty", 64'(pending_vec), 64'd0);

    // halt with {1,2}: nothing granted; release gives 1 then (after halted accept) 2.
    halt = 1'b1;
    set_vec = oh(1) | oh(2);
    tick();
    set_vec = '0;
    tick();
    grant_is("halt_none", 1'b0, 0);
    check("halt_pend", 64'(pending_vec), 64'(oh(1) | oh(2)));
    halt = 1'b0;
    tick(); grant_is("halt_g1", 1'b1, 1);
    halt = 1'b1;
    tick(); grant_is("halt_drop", 1'b0, 0);
    check("halt_pend2", 64'(pending_vec), 64'(oh(2)));
    halt = 1'b0;
    tick(); grant_is("halt_g2", 1'b1, 2);
    tick();

    // Async reset mid-stream, then search restarts at slot 0.
    set_vec = oh(10) | oh(11);
    tick();
    set_vec = '0;
    tick(); grant_is("mid_g10", 1'b1, 10);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(grant_valid), 64'd0);
    check("mid_rst_wfid", 64'(grant_wfid), 64'd0);
    check("mid_rst_pend", 64'(pending_vec), 64'd0);
    rst = 1'b0;
    tick();
    set_vec = oh(0) | oh(20);
    tick();
    set_vec = '0;
    tick(); grant_is("post_rst_g0", 1'b1, 0);
    tick(); grant_is("post_rst_g20", 1'b1, 20);
    tick(); grant_is("post_rst_idle", 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
